// File: rtl/cordic_arb_pkg.sv
// Shared types, defaults and the rotating-priority search used by the
// CORDIC vectoring arbiter and its grant encoder.
package cordic_arb_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_ID_W = 2;
    localparam int MAX_REQ  = 8;

    // One-hot sequencer states
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } arb_state_t;

    // First set bit of req, searching ptr, ptr+1, ... modulo n.
    // The loop runs downwards so the closest index to ptr is written last.
    function automatic logic [2:0] rr_search(input logic [MAX_REQ-1:0] req,
                                             input int n,
                                             input int ptr);
        logic [2:0] pick;
        int idx;
        pick = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (req[idx]) begin
                    pick = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cordic_vector_arb_rr_grant.sv
// Combinational rotating-priority encoder: picks the first active request
// at or after rr_ptr, wrapping around the request vector.
module rr_grant
    import cordic_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             any_valid,
    output logic [ID_W-1:0]  grant
);

    logic [MAX_REQ-1:0] req_ext;

    // Widen the request vector to the search width and pick the winner
    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req;
        any_valid            = |req;
        grant                = ID_W'(rr_search(req_ext, N_REQ, int'(rr_ptr)));
    end

endmodule

// File: rtl/cordic_vector_arb.sv
// Round-robin arbiter and sequencer sharing one iterative CORDIC vectoring
// engine between N_REQ requesters, with an engine-hang timeout.
module cordic_vector_arb
    import cordic_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = DEF_DW,
    parameter int ID_W    = DEF_ID_W,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_x,
    input  logic [N_REQ*DW-1:0] req_y,
    output logic [N_REQ-1:0]    req_ready,
    output logic                eng_start,
    output logic [DW-1:0]       eng_x,
    output logic [DW-1:0]       eng_y,
    input  logic                eng_done,
    input  logic [DW-1:0]       eng_phase,
    input  logic [DW-1:0]       eng_value,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DW-1:0]       rsp_phase,
    output logic [DW-1:0]       rsp_value,
    output logic                rsp_err
);

    localparam int TW = $clog2(TIMEOUT);

    arb_state_t      state;
    arb_state_t      state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] grant_c;
    logic            any_valid;
    logic [TW-1:0]   timer;
    logic            timeout_hit;

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .grant     (grant_c)
    );

    assign timeout_hit = (timer == TW'(TIMEOUT - 1));
    assign rsp_valid   = (state == RESP);
    assign eng_start   = (state == ISSUE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the combinational accept strobe
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready  = N_REQ'(1) << grant_c;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (eng_done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, wait timer, result capture and round-robin pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant     <= '0;
            timer     <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            rsp_id    <= '0;
            rsp_phase <= '0;
            rsp_value <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= grant_c;
                        eng_x <= req_x[int'(grant_c)*DW +: DW];
                        eng_y <= req_y[int'(grant_c)*DW +: DW];
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (eng_done) begin
                        rsp_phase <= eng_phase;
                        rsp_value <= eng_value;
                        rsp_err   <= 1'b0;
                        rsp_id    <= grant;
                    end else if (timeout_hit) begin
                        rsp_phase <= '0;
                        rsp_value <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= grant;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
